// File: rtl/imem_responder.sv
// Instruction-memory responder: serves fetch-unit PC requests from an internal
// word array with a fixed pipeline latency and an in-order response FIFO.
module imem_responder #(
    parameter int DEPTH      = 256,
    parameter int AW         = 8,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_instr,
    output logic [31:0]   rsp_addr,
    output logic          rsp_fault,
    input  logic          flush,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 65;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Entry layout: {fault, addr[31:0], instr[31:0]}
    logic [31:0]   mem [DEPTH];
    logic          accept;
    logic          pop;
    logic          pop_eff;
    logic          push_vld;
    logic          push_keep;
    logic          push_eff;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [EW-1:0] last_entry;
    logic [EW-1:0] out_entry;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] outstanding;

    function automatic logic addr_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
    endfunction

    function automatic logic [EW-1:0] lookup(input logic [31:0] a, input logic [31:0] word);
        logic f;
        f = addr_fault(a);
        return {f, a, (f ? NOP : word)};
    endfunction

    assign req_ready = (outstanding < CW'(FIFO_DEPTH));
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign pop_eff   = pop & ~flush;
    assign push_eff  = push_vld & (~flush | push_keep);

    // Array lookup at acceptance; a same-edge program write is not yet visible
    always_comb begin
        entry_in = lookup(req_addr, mem[req_addr[AW+1:2]]);
    end

    // Program-load port, independent of handshakes and flush
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_wdata;
    end

    generate
        if (LATENCY == 1) begin : g_direct
            // No delay stages: an accepted request lands in the FIFO at its own edge
            assign push_vld   = accept;
            assign push_entry = entry_in;
            assign push_keep  = 1'b1;
        end else begin : g_delay
            logic          vld_p [LATENCY-1];
            logic [EW-1:0] ent_p [LATENCY-1];

            // Delay-line valids: flush clears older stages, a same-cycle accept survives
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < LATENCY-1; i++) vld_p[i] <= 1'b0;
                end else begin
                    vld_p[0] <= accept;
                    for (int i = 1; i < LATENCY-1; i++) vld_p[i] <= vld_p[i-1] & ~flush;
                end
            end

            // Delay-line payload, qualified by the valids above
            always_ff @(posedge clk) begin
                ent_p[0] <= entry_in;
                for (int i = 1; i < LATENCY-1; i++) ent_p[i] <= ent_p[i-1];
            end

            assign push_vld   = vld_p[LATENCY-2];
            assign push_entry = ent_p[LATENCY-2];
            assign push_keep  = 1'b0;
        end
    endgenerate

    // FIFO payload storage
    always_ff @(posedge clk) begin
        if (push_eff) fifo_mem[wr_ptr] <= push_entry;
    end

    // FIFO pointers, occupancy, outstanding count and last-delivered response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            last_entry  <= {1'b0, 32'h0, NOP};
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + 1'b1;
            if (pop) last_entry <= fifo_mem[rd_ptr];
            if (flush) begin
                rd_ptr      <= wr_ptr;
                fifo_cnt    <= {{(CW-1){1'b0}}, push_eff};
                outstanding <= {{(CW-1){1'b0}}, accept};
            end else begin
                if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
                if (push_eff && !pop_eff)      fifo_cnt <= fifo_cnt + 1'b1;
                else if (!push_eff && pop_eff) fifo_cnt <= fifo_cnt - 1'b1;
                if (accept && !pop)            outstanding <= outstanding + 1'b1;
                else if (!accept && pop)       outstanding <= outstanding - 1'b1;
            end
        end
    end

    // Show the FIFO head while valid, otherwise hold the last delivered response
    always_comb begin
        out_entry = rsp_valid ? fifo_mem[rd_ptr] : last_entry;
    end

    assign rsp_fault = out_entry[64];
    assign rsp_addr  = out_entry[63:32];
    assign rsp_instr = out_entry[31:0];

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (DEPTH=256, LATENCY=2, FIFO_DEPTH=4).
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_fault;
    logic        flush;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [31:0] prog_wdata;

    int total  = 0;
    int passed = 0;

    imem_responder #(.DEPTH(256), .AW(8), .LATENCY(2), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_instr  (rsp_instr),
        .rsp_addr   (rsp_addr),
        .rsp_fault  (rsp_fault),
        .flush      (flush),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        rr;
        logic        pw;
        logic [7:0]  pa;
        logic [31:0] pd;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic        e_fault;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        flush      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = 8'h0;
        prog_wdata = 32'h0;
    endtask

    function automatic vec_t mk(input logic rv, input logic [31:0] ra, input logic pw,
                                input logic [7:0] pa, input logic [31:0] pd,
                                input logic e_vld, input logic [31:0] e_instr,
                                input logic [31:0] e_addr, input logic e_fault);
        vec_t v;
        v.rv = rv; v.ra = ra; v.rr = 1'b1; v.pw = pw; v.pa = pa; v.pd = pd;
        v.e_rdy = 1'b1; v.e_vld = e_vld; v.e_instr = e_instr;
        v.e_addr = e_addr; v.e_fault = e_fault;
        return v;
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        int accepted;
        logic [31:0] bp_instr [4];

        idle();
        rsp_ready = 1'b0;
        reset_n   = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;

        // Per-cycle table: inputs for the cycle, outputs expected during that cycle
        // preload mem[0..3], reset-state outputs visible
        tbl.push_back(mk(0, 32'h0,   1, 8'd0, 32'h11111111, 0, NOP, 32'h0, 0));
        tbl.push_back(mk(0, 32'h0,   1, 8'd1, 32'h22222222, 0, NOP, 32'h0, 0));
        tbl.push_back(mk(0, 32'h0,   1, 8'd2, 32'h33333333, 0, NOP, 32'h0, 0));
        tbl.push_back(mk(0, 32'h0,   1, 8'd3, 32'h44444444, 0, NOP, 32'h0, 0));
        // basic fetch: response 2 cycles after each request
        tbl.push_back(mk(1, 32'h0,   0, 8'd0, 32'h0, 0, NOP,          32'h0, 0));
        tbl.push_back(mk(1, 32'h4,   0, 8'd0, 32'h0, 0, NOP,          32'h0, 0));
        tbl.push_back(mk(1, 32'h8,   0, 8'd0, 32'h0, 1, 32'h11111111, 32'h0, 0));
        tbl.push_back(mk(1, 32'hC,   0, 8'd0, 32'h0, 1, 32'h22222222, 32'h4, 0));
        tbl.push_back(mk(0, 32'h0,   0, 8'd0, 32'h0, 1, 32'h33333333, 32'h8, 0));
        tbl.push_back(mk(0, 32'h0,   0, 8'd0, 32'h0, 1, 32'h44444444, 32'hC, 0));
        tbl.push_back(mk(0, 32'h0,   0, 8'd0, 32'h0, 0, 32'h44444444, 32'hC, 0));
        // faults: misaligned and out of range
        tbl.push_back(mk(1, 32'h2,   0, 8'd0, 32'h0, 0, 32'h44444444, 32'hC, 0));
        tbl.push_back(mk(1, 32'h400, 0, 8'd0, 32'h0, 0, 32'h44444444, 32'hC, 0));
        tbl.push_back(mk(0, 32'h0,   0, 8'd0, 32'h0, 1, NOP, 32'h2,   1));
        tbl.push_back(mk(0, 32'h0,   0, 8'd0, 32'h0, 1, NOP, 32'h400, 1));
        tbl.push_back(mk(0, 32'h0,   0, 8'd0, 32'h0, 0, NOP, 32'h400, 1));
        // program write colliding with a read of the same word
        tbl.push_back(mk(1, 32'h4,   1, 8'd1, 32'hDEADBEEF, 0, NOP, 32'h400, 1));
        tbl.push_back(mk(1, 32'h4,   0, 8'd0, 32'h0, 0, NOP,          32'h400, 1));
        tbl.push_back(mk(0, 32'h0,   0, 8'd0, 32'h0, 1, 32'h22222222, 32'h4, 0));
        tbl.push_back(mk(0, 32'h0,   0, 8'd0, 32'h0, 1, 32'hDEADBEEF, 32'h4, 0));
        tbl.push_back(mk(0, 32'h0,   0, 8'd0, 32'h0, 0, 32'hDEADBEEF, 32'h4, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            req_valid  = tbl[i].rv;
            req_addr   = tbl[i].ra;
            rsp_ready  = tbl[i].rr;
            prog_we    = tbl[i].pw;
            prog_addr  = tbl[i].pa;
            prog_wdata = tbl[i].pd;
            #1;
            chk($sformatf("vec%0d.req_ready", i), {31'h0, req_ready}, {31'h0, tbl[i].e_rdy});
            chk($sformatf("vec%0d.rsp_valid", i), {31'h0, rsp_valid}, {31'h0, tbl[i].e_vld});
            chk($sformatf("vec%0d.rsp_instr", i), rsp_instr, tbl[i].e_instr);
            chk($sformatf("vec%0d.rsp_addr", i),  rsp_addr,  tbl[i].e_addr);
            chk($sformatf("vec%0d.rsp_fault", i), {31'h0, rsp_fault}, {31'h0, tbl[i].e_fault});
            step();
        end
        idle();

        // Backpressure: consumer stalled, fetch unit keeps requesting
        bp_instr[0] = 32'h11111111;
        bp_instr[1] = 32'hDEADBEEF;
        bp_instr[2] = 32'h33333333;
        bp_instr[3] = 32'h44444444;
        accepted  = 0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1;
            req_addr  = 32'(accepted * 4);
            #1;
            if (c == 5 || c == 7) begin
                chk("bp_hold.rsp_instr", rsp_instr, 32'h11111111);
                chk("bp_hold.rsp_addr",  rsp_addr,  32'h0);
            end
            if (req_ready) accepted++;
            step();
        end
        idle();
        chk("bp.accepted",  32'(accepted), 32'd4);
        chk("bp.req_ready", {31'h0, req_ready}, 32'h0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp_rsp%0d.valid", i), {31'h0, rsp_valid}, 32'h1);
            chk($sformatf("bp_rsp%0d.addr", i),  rsp_addr,  32'(i * 4));
            chk($sformatf("bp_rsp%0d.instr", i), rsp_instr, bp_instr[i]);
            step();
        end
        chk("bp_done.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("bp_done.req_ready", {31'h0, req_ready}, 32'h1);

        // Flush redirect: three queued requests dropped, the same-cycle one kept
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h0;
        prog_we    = 1'b1;
        prog_addr  = 8'd8;
        prog_wdata = 32'h99999999;
        step();
        prog_we  = 1'b0;
        req_addr = 32'h4;
        step();
        req_addr = 32'h8;
        step();
        req_addr = 32'h20;
        flush    = 1'b1;
        #1;
        chk("flush.req_ready", {31'h0, req_ready}, 32'h1);
        step();
        idle();
        rsp_ready = 1'b1;
        chk("flush+1.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        step();
        chk("flush+2.rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("flush+2.rsp_addr",  rsp_addr,  32'h20);
        chk("flush+2.rsp_instr", rsp_instr, 32'h99999999);
        chk("flush+2.rsp_fault", {31'h0, rsp_fault}, 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("flush_after%0d.rsp_valid", i), {31'h0, rsp_valid}, 32'h0);
            step();
        end

        // Asynchronous reset with three requests outstanding
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i * 4);
            step();
        end
        idle();
        chk("pre_reset.rsp_valid", {31'h0, rsp_valid}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("reset.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset.rsp_instr", rsp_instr, NOP);
        chk("reset.rsp_addr",  rsp_addr,  32'h0);
        chk("reset.rsp_fault", {31'h0, rsp_fault}, 32'h0);
        #1 reset_n = 1'b1;
        step();
        chk("post_reset.req_ready", {31'h0, req_ready}, 32'h1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("post_reset%0d.rsp_valid", i), {31'h0, rsp_valid}, 32'h0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
